lsu: RTL and testbench
======================

# lsu

Load/store unit forming the MEM stage of the 5-stage core, directly downstream of the execute ALU. It takes the ALU result (register write or effective address) plus the store operand, performs at most one data-bus transaction per instruction with a req/gnt/rvalid handshake, and aligns and sign-extends load data. It presents a registered write-back record to the WB stage. It back-pressures EX through `o_ready` while a bus access is outstanding.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (only 32 supported)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_valid  in  1  EX presents an instruction this cycle
- o_ready  out  1  LSU accepts; transfer when i_valid & o_ready
- i_load  in  1  instruction is a load
- i_store  in  1  instruction is a store
- i_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- i_unsigned  in  1  zero-extend load (LBU/LHU)
- i_addr  in  AW  effective address (ALU `o_write_data` for loads/stores)
- i_store_data  in  DW  rs2 value
- i_rd  in  5  destination register
- i_alu_write_en  in  1  ALU write enable (non-memory instructions)
- i_alu_write_data  in  DW  ALU result
- o_bus_req  out  1  data-bus request
- o_bus_we  out  1  1 store, 0 load
- o_bus_addr  out  AW  word-aligned address {i_addr[AW-1:2],2'b00}
- o_bus_wdata  out  DW  lane-replicated store data
- o_bus_be  out  4  byte enables
- i_bus_gnt  in  1  request accepted this cycle
- i_bus_rvalid  in  1  response (read data / write ack) valid
- i_bus_rdata  in  DW  read data
- o_wb_valid  out  1  one-cycle write-back record valid
- o_wb_en  out  1  register write enable
- o_wb_rd  out  5  destination register
- o_wb_data  out  DW  write-back data
- o_misalign  out  1  qualifies o_wb_valid: access was misaligned, no bus access, no write

## Operation
- FSM states: IDLE, REQ, RESP. `o_ready` = (state == IDLE).
- IDLE, accept, not load/store: register ALU record: o_wb_valid=1, o_wb_en = i_alu_write_en & (i_rd != 0), data = i_alu_write_data. Stay IDLE.
- IDLE, accept, load/store, misaligned (half with addr[0]=1; word with addr[1:0]!=0): o_wb_valid=1, o_misalign=1, o_wb_en=0. Stay IDLE.
- IDLE, accept, aligned load/store: latch rd/size/unsigned/addr[1:0]; drive bus outputs from registers; go to REQ.
- REQ: o_bus_req=1, bus outputs held stable until i_bus_gnt; on gnt go to RESP.
- RESP: on i_bus_rvalid emit record and go to IDLE. Load: o_wb_en = (rd != 0), data = extracted lane, sign- or zero-extended. Store: o_wb_en=0.
- Byte enables: byte 4'b0001<<addr[1:0], wdata {4{d[7:0]}}. Half addr[1]?4'b1100:4'b0011, wdata {2{d[15:0]}}. Word 4'b1111, wdata d.
- Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
- i_bus_rvalid outside RESP is ignored. i_bus_gnt outside REQ is ignored.

## Timing
- Reset values: state IDLE, o_wb_valid 0, o_wb_en 0, o_wb_rd 0, o_wb_data 0, o_misalign 0, o_bus_req 0, o_bus_we 0, o_bus_addr 0, o_bus_wdata 0, o_bus_be 0. o_ready is 1 in the cycle after reset.
- Non-memory or misaligned instruction: accepted at cycle t, record at t+1. Back-to-back acceptance every cycle.
- Load/store: accepted at t, req asserted t+1. If gnt at t+1 and rvalid at t+2, record at t+3. Each gnt/rvalid wait cycle adds one cycle.
- o_wb_valid is a single-cycle pulse. All outputs are registered.
- gnt and rvalid in the same cycle are not allowed (rvalid is earliest the cycle after gnt).
- Reset in REQ/RESP: return to IDLE next cycle, req dropped. A late rvalid is ignored and no record is emitted.

## Structure
- Shared package `core_pkg`: `lsu_state_t` enum {IDLE, REQ, RESP}, size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- Sub-module `lsu_align`: combinational store lane/BE generation and load extract/extend. The FSM and registers stay in `lsu`.

## Test plan
- ALU op i_rd=5, data 0x1234 -> o_wb_valid at t+1, wb_en=1, rd=5, data 0x1234. Same with rd=0 -> wb_en=0.
- SB addr 0x1003, data 0xAB -> be 4'b1000, wdata 0xABABABAB, bus_addr 0x1000, we=1. Record wb_en=0 after rvalid.
- LB addr 0x2001, rdata 0x0000_8000 -> data 0xFFFFFF80. LBU -> 0x00000080.
- LH addr 0x2002, rdata 0x8765_0000 -> 0xFFFF8765. LW with gnt held off 3 cycles and rvalid 2 cycles later -> req stable, o_ready=0 throughout, record exactly once.
- LW addr 0x3002 -> no o_bus_req, o_misalign=1, wb_en=0 at t+1.
- Reset asserted in RESP, rvalid pulsed after reset -> no o_wb_valid, all outputs at reset values, o_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions used by the load/store unit: FSM state
// encoding, access-size codes and the alignment check.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Halfwords need bit 0 clear; words (and the illegal size 3, which
  // behaves as a word) need both low bits clear.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte-enable and data
// replication, and load lane extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  // Per-lane store data and byte enable: bytes are copied to every lane,
  // halves to both half-lanes, words pass straight through.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata[8*gi +: 8] = (st_size == SZ_BYTE) ? st_data[7:0] :
                              (st_size == SZ_HALF) ? st_data[8*(gi%2) +: 8] :
                                                     st_data[8*gi +: 8];
    assign be[gi] = (st_size == SZ_BYTE) ? (st_addr_lo == 2'(gi)) :
                    (st_size == SZ_HALF) ? (st_addr_lo[1] == 1'(gi/2)) :
                                           1'b1;
  end

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_lane = rdata[{ld_addr_lo, 3'b000} +: 8];
    half_lane = rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{byte_lane[7] & ~ld_unsigned}}, byte_lane};
      SZ_HALF: ld_data = {{16{half_lane[15] & ~ld_unsigned}}, half_lane};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit. Passes ALU results through as write-back
// records, runs one req/gnt/rvalid bus transaction per aligned memory
// instruction, and stalls EX while that transaction is in flight.
module lsu
  import core_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_load,
  input  logic          i_store,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_store_data,
  input  logic [4:0]    i_rd,
  input  logic          i_alu_write_en,
  input  logic [DW-1:0] i_alu_write_data,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  output logic [3:0]    o_bus_be,
  input  logic          i_bus_gnt,
  input  logic          i_bus_rvalid,
  input  logic [DW-1:0] i_bus_rdata,
  output logic          o_wb_valid,
  output logic          o_wb_en,
  output logic [4:0]    o_wb_rd,
  output logic [DW-1:0] o_wb_data,
  output logic          o_misalign
);

  lsu_state_t state_reg, state_next;

  logic          bus_req_reg, bus_req_next;
  logic          bus_we_reg, bus_we_next;
  logic [AW-1:0] bus_addr_reg, bus_addr_next;
  logic [DW-1:0] bus_wdata_reg, bus_wdata_next;
  logic [3:0]    bus_be_reg, bus_be_next;

  logic          wb_valid_reg, wb_valid_next;
  logic          wb_en_reg, wb_en_next;
  logic [4:0]    wb_rd_reg, wb_rd_next;
  logic [DW-1:0] wb_data_reg, wb_data_next;
  logic          misalign_reg, misalign_next;

  // Context of the outstanding memory access, needed when rvalid arrives.
  logic [4:0]    rd_reg, rd_next;
  logic [1:0]    size_reg, size_next;
  logic          uns_reg, uns_next;
  logic [1:0]    addr_lo_reg, addr_lo_next;
  logic          is_load_reg, is_load_next;

  logic [3:0]    st_be;
  logic [DW-1:0] st_wdata;
  logic [DW-1:0] ld_data;

  lsu_align u_align (
    .st_size    (i_size),
    .st_addr_lo (i_addr[1:0]),
    .st_data    (i_store_data),
    .be         (st_be),
    .wdata      (st_wdata),
    .ld_size    (size_reg),
    .ld_addr_lo (addr_lo_reg),
    .ld_unsigned(uns_reg),
    .rdata      (i_bus_rdata),
    .ld_data    (ld_data)
  );

  // Next-state and registered-output logic; the write-back record is a
  // single-cycle pulse so its valid/enable/misalign default low.
  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_be_next    = bus_be_reg;
    wb_valid_next  = 1'b0;
    wb_en_next     = 1'b0;
    wb_rd_next     = wb_rd_reg;
    wb_data_next   = wb_data_reg;
    misalign_next  = 1'b0;
    rd_next        = rd_reg;
    size_next      = size_reg;
    uns_next       = uns_reg;
    addr_lo_next   = addr_lo_reg;
    is_load_next   = is_load_reg;

    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          if (i_load || i_store) begin
            if (is_misaligned(i_size, i_addr[1:0])) begin
              wb_valid_next = 1'b1;
              misalign_next = 1'b1;
              wb_rd_next    = i_rd;
              wb_data_next  = '0;
            end else begin
              bus_req_next   = 1'b1;
              bus_we_next    = ~i_load;
              bus_addr_next  = {i_addr[AW-1:2], 2'b00};
              bus_wdata_next = st_wdata;
              bus_be_next    = st_be;
              rd_next        = i_rd;
              size_next      = i_size;
              uns_next       = i_unsigned;
              addr_lo_next   = i_addr[1:0];
              is_load_next   = i_load;
              state_next     = REQ;
            end
          end else begin
            wb_valid_next = 1'b1;
            wb_en_next    = i_alu_write_en & (i_rd != 5'd0);
            wb_rd_next    = i_rd;
            wb_data_next  = i_alu_write_data;
          end
        end
      end
      REQ: begin
        if (i_bus_gnt) begin
          bus_req_next = 1'b0;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (i_bus_rvalid) begin
          wb_valid_next = 1'b1;
          wb_en_next    = is_load_reg & (rd_reg != 5'd0);
          wb_rd_next    = rd_reg;
          wb_data_next  = is_load_reg ? ld_data : '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_be_reg    <= '0;
      wb_valid_reg  <= 1'b0;
      wb_en_reg     <= 1'b0;
      wb_rd_reg     <= '0;
      wb_data_reg   <= '0;
      misalign_reg  <= 1'b0;
      rd_reg        <= '0;
      size_reg      <= SZ_BYTE;
      uns_reg       <= 1'b0;
      addr_lo_reg   <= '0;
      is_load_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_be_reg    <= bus_be_next;
      wb_valid_reg  <= wb_valid_next;
      wb_en_reg     <= wb_en_next;
      wb_rd_reg     <= wb_rd_next;
      wb_data_reg   <= wb_data_next;
      misalign_reg  <= misalign_next;
      rd_reg        <= rd_next;
      size_reg      <= size_next;
      uns_reg       <= uns_next;
      addr_lo_reg   <= addr_lo_next;
      is_load_reg   <= is_load_next;
    end
  end

  assign o_ready     = (state_reg == IDLE);
  assign o_bus_req   = bus_req_reg;
  assign o_bus_we    = bus_we_reg;
  assign o_bus_addr  = bus_addr_reg;
  assign o_bus_wdata = bus_wdata_reg;
  assign o_bus_be    = bus_be_reg;
  assign o_wb_valid  = wb_valid_reg;
  assign o_wb_en     = wb_en_reg;
  assign o_wb_rd     = wb_rd_reg;
  assign o_wb_data   = wb_data_reg;
  assign o_misalign  = misalign_reg;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: table of instructions with hand-computed expected
// bus and write-back values, a scoreboard queue for write-back records,
// plus hand-written sequences for ignored handshakes and reset mid-access.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_load, i_store, i_unsigned;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_store_data, i_alu_write_data;
  logic [4:0]  i_rd;
  logic        i_alu_write_en;
  logic        o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt, i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic        o_wb_valid, o_wb_en, o_misalign;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  always #5 clk = ~clk;

  lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_load(i_load), .i_store(i_store), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_store_data(i_store_data),
    .i_rd(i_rd), .i_alu_write_en(i_alu_write_en),
    .i_alu_write_data(i_alu_write_data), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_be(o_bus_be), .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid),
    .i_bus_rdata(i_bus_rdata), .o_wb_valid(o_wb_valid), .o_wb_en(o_wb_en),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_misalign(o_misalign)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } rec_t;

  rec_t sb_q[$];

  // Scoreboard: every write-back pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (o_wb_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL wb_unexpected: got o_wb_valid=%b expected no record", o_wb_valid);
      end else begin
        rec_t e;
        e = sb_q.pop_front();
        chk("wb_en", {31'd0, o_wb_en}, {31'd0, e.en});
        chk("wb_misalign", {31'd0, o_misalign}, {31'd0, e.mis});
        if (e.en) begin
          chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, e.rd});
          chk("wb_data", o_wb_data, e.data);
        end
      end
    end
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        alu_we;
    logic [31:0] alu_data;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_en;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic apply(input int idx, input vec_t v);
    rec_t r;
    logic mem;
    mem = v.ld | v.st;
    @(negedge clk);
    i_valid = 1'b1; i_load = v.ld; i_store = v.st; i_size = v.size;
    i_unsigned = v.uns; i_addr = v.addr; i_store_data = v.sdata;
    i_rd = v.rd; i_alu_write_en = v.alu_we; i_alu_write_data = v.alu_data;
    r.en = v.exp_en; r.rd = v.rd; r.data = v.exp_data; r.mis = v.exp_mis;
    sb_q.push_back(r);
    $display("vec %0d: ld=%b st=%b size=%0d addr=%h rd=%0d", idx, v.ld, v.st,
             v.size, v.addr, v.rd);
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
    if (mem && v.exp_mis) begin
      chk("misalign_no_req", {31'd0, o_bus_req}, 32'd0);
    end else if (mem) begin
      for (int k = 0; k <= v.gdly; k++) begin
        @(negedge clk);
        chk("req_high", {31'd0, o_bus_req}, 32'd1);
        chk("ready_low_req", {31'd0, o_ready}, 32'd0);
        chk("bus_addr", o_bus_addr, v.addr & 32'hFFFF_FFFC);
        chk("bus_we", {31'd0, o_bus_we}, {31'd0, v.st});
        chk("bus_be", {28'd0, o_bus_be}, {28'd0, v.exp_be});
        if (v.st) chk("bus_wdata", o_bus_wdata, v.exp_wdata);
        i_bus_gnt = (k == v.gdly);
        @(posedge clk);
        #1 i_bus_gnt = 1'b0;
      end
      for (int k = 0; k <= v.rdly; k++) begin
        @(negedge clk);
        chk("req_dropped", {31'd0, o_bus_req}, 32'd0);
        chk("ready_low_resp", {31'd0, o_ready}, 32'd0);
        i_bus_rvalid = (k == v.rdly);
        i_bus_rdata = v.rdata;
        @(posedge clk);
        #1 i_bus_rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ld  st  size  uns addr          sdata         rd    we  alu_data      rdata         g  r  be       wdata         en  data          mis
    vecs[0]  = '{0, 0, 2'd0, 0, 32'h0,        32'h0,        5'd5, 1, 32'h0000_1234, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h0000_1234, 0};
    vecs[1]  = '{0, 0, 2'd0, 0, 32'h0,        32'h0,        5'd0, 1, 32'h0000_1234, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        0};
    vecs[2]  = '{0, 1, 2'd0, 0, 32'h0000_1003, 32'h0000_00AB, 5'd7, 0, 32'h0,        32'h0,        0, 0, 4'b1000, 32'hABAB_ABAB, 0, 32'h0,        0};
    vecs[3]  = '{1, 0, 2'd0, 0, 32'h0000_2001, 32'h0,        5'd3, 0, 32'h0,        32'h0000_8000, 0, 0, 4'b0010, 32'h0,        1, 32'hFFFF_FF80, 0};
    vecs[4]  = '{1, 0, 2'd0, 1, 32'h0000_2001, 32'h0,        5'd4, 0, 32'h0,        32'h0000_8000, 1, 1, 4'b0010, 32'h0,        1, 32'h0000_0080, 0};
    vecs[5]  = '{1, 0, 2'd1, 0, 32'h0000_2002, 32'h0,        5'd6, 0, 32'h0,        32'h8765_0000, 0, 0, 4'b1100, 32'h0,        1, 32'hFFFF_8765, 0};
    vecs[6]  = '{1, 0, 2'd2, 0, 32'h0000_2000, 32'h0,        5'd9, 0, 32'h0,        32'hDEAD_BEEF, 3, 2, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF, 0};
    vecs[7]  = '{1, 0, 2'd2, 0, 32'h0000_3002, 32'h0,        5'd8, 0, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1};
    vecs[8]  = '{0, 1, 2'd1, 0, 32'h0000_4002, 32'h1234_5678, 5'd2, 0, 32'h0,        32'h0,        1, 0, 4'b1100, 32'h5678_5678, 0, 32'h0,        0};
    vecs[9]  = '{1, 0, 2'd1, 1, 32'h0000_4000, 32'h0,        5'd10, 0, 32'h0,       32'h1234_F00D, 0, 1, 4'b0011, 32'h0,        1, 32'h0000_F00D, 0};
    vecs[10] = '{1, 0, 2'd0, 0, 32'h0000_4003, 32'h0,        5'd0, 0, 32'h0,        32'hFF00_0000, 0, 0, 4'b1000, 32'h0,        0, 32'h0,        0};
    vecs[11] = '{0, 1, 2'd2, 0, 32'h0000_5004, 32'hCAFE_F00D, 5'd1, 0, 32'h0,        32'h0,        2, 0, 4'b1111, 32'hCAFE_F00D, 0, 32'h0,        0};
    vecs[12] = '{1, 0, 2'd1, 0, 32'h0000_2001, 32'h0,        5'd11, 0, 32'h0,       32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1};
    vecs[13] = '{1, 0, 2'd0, 0, 32'h0000_6002, 32'h0,        5'd12, 0, 32'h0,       32'h007F_0000, 0, 0, 4'b0100, 32'h0,        1, 32'h0000_007F, 0};

    rst = 1'b1; i_valid = 0; i_load = 0; i_store = 0; i_size = 0;
    i_unsigned = 0; i_addr = 0; i_store_data = 0; i_rd = 0;
    i_alu_write_en = 0; i_alu_write_data = 0; i_bus_gnt = 0;
    i_bus_rvalid = 0; i_bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_req", {31'd0, o_bus_req}, 32'd0);
    chk("rst_be", {28'd0, o_bus_be}, 32'd0);
    chk("rst_addr", o_bus_addr, 32'd0);
    chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Stray gnt and rvalid while idle are ignored: no request, no record.
    @(negedge clk); i_bus_gnt = 1'b1;
    @(negedge clk); i_bus_gnt = 1'b0; i_bus_rvalid = 1'b1;
    @(negedge clk); i_bus_rvalid = 1'b0;
    $display("seq stray handshakes while idle");
    chk("stray_no_req", {31'd0, o_bus_req}, 32'd0);
    chk("stray_ready", {31'd0, o_ready}, 32'd1);

    // Reset while waiting for the response; a late rvalid is dropped.
    $display("seq reset in RESP");
    @(negedge clk);
    i_valid = 1'b1; i_load = 1'b1; i_size = 2'd2; i_addr = 32'h0000_7000; i_rd = 5'd13;
    @(posedge clk); #1 i_valid = 1'b0; i_load = 1'b0;
    @(negedge clk); i_bus_gnt = 1'b1;
    @(posedge clk); #1 i_bus_gnt = 1'b0;
    @(negedge clk);
    chk("resp_ready_low", {31'd0, o_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1111_2222;
    @(posedge clk); #1 i_bus_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
    chk("post_rst_req", {31'd0, o_bus_req}, 32'd0);
    chk("post_rst_we", {31'd0, o_bus_we}, 32'd0);
    chk("post_rst_addr", o_bus_addr, 32'd0);
    chk("post_rst_wdata", o_bus_wdata, 32'd0);
    chk("post_rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("post_rst_wb_en", {31'd0, o_wb_en}, 32'd0);
    chk("post_rst_wb_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("post_rst_wb_data", o_wb_data, 32'd0);
    chk("post_rst_misalign", {31'd0, o_misalign}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_all_records_seen", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
